// File: rtl/csr_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_pkg
//   Shared definitions for the CSR trap controller:
//   - bus widths and the machine timer interrupt cause value
//   - machine-mode CSR addresses touched by the trap/mret sequences
//   - mstatus / mie bit positions
//   - trap controller FSM state encoding
//   - mstatus rewrite helpers for trap entry and mret
// ---------------------------------------------------------------------------
package csr_trap_ctrl_pkg;

   localparam int XLEN_D   = 32;
   localparam int CSR_AW_D = 12;

   localparam logic [XLEN_D-1:0] IRQ_CAUSE_D = 32'h8000_0007;

   // Machine-mode CSR addresses
   localparam logic [CSR_AW_D-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CSR_AW_D-1:0] CSR_MIE     = 12'h304;
   localparam logic [CSR_AW_D-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CSR_AW_D-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CSR_AW_D-1:0] CSR_MCAUSE  = 12'h342;
   localparam logic [CSR_AW_D-1:0] CSR_MTVAL   = 12'h343;

   // mstatus bit positions
   localparam int MS_MIE    = 3;
   localparam int MS_MPIE   = 7;
   localparam int MS_MPP_LO = 11;
   localparam int MS_MPP_HI = 12;

   // mie bit position of the machine timer interrupt enable
   localparam int MIE_MTIE = 7;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CHK_MS    = 4'd1,
      S_CHK_MIE   = 4'd2,
      S_W_MEPC    = 4'd3,
      S_W_MCAUSE  = 4'd4,
      S_W_MTVAL   = 4'd5,
      S_W_MSTATUS = 4'd6,
      S_R_MSTATUS = 4'd7,
      S_JUMP      = 4'd8
   } state_e;

   // Trap entry: stack MIE into MPIE, disable interrupts, record M-mode in MPP.
   function automatic logic [XLEN_D-1:0] trap_mstatus(input logic [XLEN_D-1:0] old);
      logic [XLEN_D-1:0] v;
      v                        = old;
      v[MS_MPP_HI:MS_MPP_LO]   = 2'b11;
      v[MS_MPIE]               = old[MS_MIE];
      v[MS_MIE]                = 1'b0;
      return v;
   endfunction

   // mret: restore MIE from MPIE and set MPIE.
   function automatic logic [XLEN_D-1:0] mret_mstatus(input logic [XLEN_D-1:0] old);
      logic [XLEN_D-1:0] v;
      v          = old;
      v[MS_MIE]  = old[MS_MPIE];
      v[MS_MPIE] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//   Sole master of the CSR register file port. While idle it passes the
//   pipeline's CSR accesses straight through (EX write, ID read). On an
//   exception, a taken timer interrupt or an mret it takes the port, runs a
//   short sequence of CSR reads/writes (one per cycle) and finishes with a
//   one-cycle fetch redirect. The pipeline is held while the port is owned.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ex_csr_wr_*        pipeline CSR write request (EX stage)
//   id_csr_rd_addr/data pipeline CSR read (ID stage)
//   exc_req/cause/pc/tval  synchronous exception pulse and its trap info
//   mret_req           mret retiring in EX (pulse)
//   irq_timer, irq_pc  level timer interrupt, PC to resume at
//   csr_wr_*, csr_rd_* port to the CSR register file (read is combinational)
//   hold_o             pipeline stall
//   jump_en/jump_addr  one-cycle fetch redirect
// ---------------------------------------------------------------------------
module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
#(
   parameter int                XLEN      = XLEN_D,
   parameter int                CSR_AW    = CSR_AW_D,
   parameter logic [XLEN-1:0]   IRQ_CAUSE = IRQ_CAUSE_D
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ex_csr_wr_en,
   input  logic [CSR_AW-1:0] ex_csr_wr_addr,
   input  logic [XLEN-1:0]   ex_csr_wr_data,
   input  logic [CSR_AW-1:0] id_csr_rd_addr,
   output logic [XLEN-1:0]   id_csr_rd_data,

   input  logic              exc_req,
   input  logic [XLEN-1:0]   exc_cause,
   input  logic [XLEN-1:0]   exc_pc,
   input  logic [XLEN-1:0]   exc_tval,
   input  logic              mret_req,
   input  logic              irq_timer,
   input  logic [XLEN-1:0]   irq_pc,

   output logic              csr_wr_en,
   output logic [CSR_AW-1:0] csr_wr_addr,
   output logic [XLEN-1:0]   csr_wr_data,
   output logic [CSR_AW-1:0] csr_rd_addr,
   input  logic [XLEN-1:0]   csr_rd_data,

   output logic              hold_o,
   output logic              jump_en,
   output logic [XLEN-1:0]   jump_addr
);

   state_e          state_q;
   logic            mret_q;      // 1: JUMP returns to mepc, 0: JUMP enters mtvec
   logic            mie_bit_q;   // mstatus.MIE captured in CHK_MS
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] tval_q;

   // -----------------------------------------------------------------------
   // Sequencer
   // -----------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // in this block sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mret_q    <= 1'b0;
         mie_bit_q <= 1'b0;
         pc_q      <= '0;
         cause_q   <= '0;
         tval_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Requests are only honoured here; priority exc > mret > irq.
               if (exc_req) begin
                  pc_q    <= exc_pc;
                  cause_q <= exc_cause;
                  tval_q  <= exc_tval;
                  mret_q  <= 1'b0;
                  state_q <= S_W_MEPC;
               end else if (mret_req) begin
                  mret_q  <= 1'b1;
                  state_q <= S_R_MSTATUS;
               end else if (irq_timer) begin
                  state_q <= S_CHK_MS;
               end
            end
            S_CHK_MS: begin
               mie_bit_q <= csr_rd_data[MS_MIE];
               state_q   <= S_CHK_MIE;
            end
            S_CHK_MIE: begin
               if (mie_bit_q && csr_rd_data[MIE_MTIE]) begin
                  pc_q    <= irq_pc;
                  cause_q <= IRQ_CAUSE;
                  tval_q  <= '0;
                  mret_q  <= 1'b0;
                  state_q <= S_W_MEPC;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_W_MEPC:    state_q <= S_W_MCAUSE;
            S_W_MCAUSE:  state_q <= S_W_MTVAL;
            S_W_MTVAL:   state_q <= S_W_MSTATUS;
            S_W_MSTATUS: state_q <= S_JUMP;
            S_R_MSTATUS: state_q <= S_JUMP;
            S_JUMP:      state_q <= S_IDLE;
            default:     state_q <= S_IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // CSR port mux and redirect
   // -----------------------------------------------------------------------
   // NOTE: every output gets a default before the case so no path through
   // this block can infer a latch.
   always_comb begin
      csr_wr_en      = 1'b0;
      csr_wr_addr    = '0;
      csr_wr_data    = '0;
      csr_rd_addr    = '0;
      id_csr_rd_data = '0;
      jump_en        = 1'b0;
      jump_addr      = '0;

      case (state_q)
         S_IDLE: begin
            csr_wr_en      = ex_csr_wr_en;
            csr_wr_addr    = ex_csr_wr_addr;
            csr_wr_data    = ex_csr_wr_data;
            csr_rd_addr    = id_csr_rd_addr;
            id_csr_rd_data = csr_rd_data;
         end
         S_CHK_MS:  csr_rd_addr = CSR_MSTATUS;
         S_CHK_MIE: csr_rd_addr = CSR_MIE;
         S_W_MEPC: begin
            csr_wr_en   = 1'b1;
            csr_wr_addr = CSR_MEPC;
            csr_wr_data = pc_q;
         end
         S_W_MCAUSE: begin
            csr_wr_en   = 1'b1;
            csr_wr_addr = CSR_MCAUSE;
            csr_wr_data = cause_q;
         end
         S_W_MTVAL: begin
            csr_wr_en   = 1'b1;
            csr_wr_addr = CSR_MTVAL;
            csr_wr_data = tval_q;
         end
         S_W_MSTATUS: begin
            // Read-modify-write of mstatus in a single cycle.
            csr_rd_addr = CSR_MSTATUS;
            csr_wr_en   = 1'b1;
            csr_wr_addr = CSR_MSTATUS;
            csr_wr_data = trap_mstatus(csr_rd_data);
         end
         S_R_MSTATUS: begin
            csr_rd_addr = CSR_MSTATUS;
            csr_wr_en   = 1'b1;
            csr_wr_addr = CSR_MSTATUS;
            csr_wr_data = mret_mstatus(csr_rd_data);
         end
         S_JUMP: begin
            jump_en = 1'b1;
            if (mret_q) begin
               csr_rd_addr = CSR_MEPC;
               jump_addr   = csr_rd_data;
            end else begin
               // Direct mode only: mtvec mode bits are dropped.
               csr_rd_addr = CSR_MTVEC;
               jump_addr   = {csr_rd_data[XLEN-1:2], 2'b00};
            end
         end
         default: ;
      endcase

      // A reset cycle must not commit a write or a redirect, even mid-sequence.
      if (rst) begin
         csr_wr_en = 1'b0;
         jump_en   = 1'b0;
         jump_addr = '0;
      end
   end

   // Stall as soon as a request appears so the requesting instruction
   // does not advance while the sequence starts.
   assign hold_o = !rst && ((state_q != S_IDLE) || exc_req || mret_req || irq_timer);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl
//   Self-checking bench for csr_trap_ctrl. A small CSR register file model
//   answers the DUT's port; each scenario builds the expected list of CSR
//   writes, redirect cycle/target and stall profile from the trap rules and
//   compares them against what the DUT did, cycle by cycle.
// ---------------------------------------------------------------------------
module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_csr_wr_en;
   logic [11:0] ex_csr_wr_addr;
   logic [31:0] ex_csr_wr_data;
   logic [11:0] id_csr_rd_addr;
   logic [31:0] id_csr_rd_data;
   logic        exc_req;
   logic [31:0] exc_cause, exc_pc, exc_tval;
   logic        mret_req;
   logic        irq_timer;
   logic [31:0] irq_pc;
   logic        csr_wr_en;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_wr_data;
   logic [11:0] csr_rd_addr;
   logic [31:0] csr_rd_data;
   logic        hold_o;
   logic        jump_en;
   logic [31:0] jump_addr;

   always #5 clk = ~clk;

   csr_trap_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ex_csr_wr_en   (ex_csr_wr_en),
      .ex_csr_wr_addr (ex_csr_wr_addr),
      .ex_csr_wr_data (ex_csr_wr_data),
      .id_csr_rd_addr (id_csr_rd_addr),
      .id_csr_rd_data (id_csr_rd_data),
      .exc_req        (exc_req),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret_req       (mret_req),
      .irq_timer      (irq_timer),
      .irq_pc         (irq_pc),
      .csr_wr_en      (csr_wr_en),
      .csr_wr_addr    (csr_wr_addr),
      .csr_wr_data    (csr_wr_data),
      .csr_rd_addr    (csr_rd_addr),
      .csr_rd_data    (csr_rd_data),
      .hold_o         (hold_o),
      .jump_en        (jump_en),
      .jump_addr      (jump_addr)
   );

   // ---------------- CSR register file model ----------------
   logic [31:0] regs [0:4095];
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) regs[pl_addr] <= pl_data;
      else if (csr_wr_en) regs[csr_wr_addr] <= csr_wr_data;
   end

   // Write-bypassed read for the pipeline path (same-cycle EX write -> ID read).
   always_comb begin
      csr_rd_data = regs[csr_rd_addr];
      if (csr_wr_en && !hold_o && (csr_wr_addr == csr_rd_addr))
         csr_rd_data = ex_csr_wr_data;
   end

   // ---------------- bookkeeping ----------------
   typedef struct {
      int          c;
      logic [11:0] a;
      logic [31:0] d;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         wr_q[$];
   wr_t         exp_q[$];
   int          jmp_c[$];
   logic [31:0] jmp_a[$];
   logic        hold_log  [0:31];
   logic [31:0] idrd_log  [0:31];

   // Expected mstatus rewrites, from the architectural rules.
   function automatic logic [31:0] exp_trap_ms(input logic [31:0] old);
      return (old & 32'hFFFF_E777) | 32'h0000_1800 | (old[3] ? 32'h80 : 32'h0);
   endfunction
   function automatic logic [31:0] exp_mret_ms(input logic [31:0] old);
      return (old & 32'hFFFF_FFF7) | 32'h80 | (old[7] ? 32'h8 : 32'h0);
   endfunction

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Drive one scenario for ncyc cycles starting at cycle 0 and log what the
   // DUT does on each cycle (sampled at the falling edge).
   task automatic observe(input int ncyc, input logic [31:0] exc_mask,
                          input logic [31:0] mret_mask, input int irq_len,
                          input int rst_at, input bit ex_noise);
      wr_q.delete(); jmp_c.delete(); jmp_a.delete();
      for (int c = 0; c < ncyc; c++) begin
         exc_req        = exc_mask[c];
         mret_req       = mret_mask[c];
         irq_timer      = (c < irq_len);
         rst            = (c == rst_at);
         ex_csr_wr_en   = ex_noise && (c >= 1) && (c <= 4);
         ex_csr_wr_addr = 12'h7C0;
         ex_csr_wr_data = $urandom;
         @(negedge clk);
         hold_log[c] = hold_o;
         idrd_log[c] = id_csr_rd_data;
         if (csr_wr_en) wr_q.push_back('{c: c, a: csr_wr_addr, d: csr_wr_data});
         if (jump_en) begin
            jmp_c.push_back(c);
            jmp_a.push_back(jump_addr);
         end
         @(posedge clk); #1;
      end
      exc_req = 1'b0; mret_req = 1'b0; irq_timer = 1'b0; rst = 1'b0;
      ex_csr_wr_en = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; ex_csr_wr_en = 1'b1; ex_csr_wr_addr = 12'h340;
      ex_csr_wr_data = 32'h1234_5678; irq_timer = 1'b1; exc_req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (hold_o !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b expected 0", hold_o); end
      checks++;
      if (csr_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", csr_wr_en); end
      checks++;
      if (jump_en !== 1'b0) begin errors++; $display("FAIL rst_jump_en: got %b expected 0", jump_en); end
      @(posedge clk); #1;
      rst = 1'b0; ex_csr_wr_en = 1'b0; irq_timer = 1'b0; exc_req = 1'b0;
      @(negedge clk);
      checks++;
      if (hold_o !== 1'b0) begin errors++; $display("FAIL post_rst_hold: got %b expected 0", hold_o); end
      checks++;
      if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
         errors++; $display("FAIL post_rst_jump: got en=%b addr=%h expected 0/0", jump_en, jump_addr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      logic [11:0] wa, ra;
      logic [31:0] wd, exp_rd;
      logic        we;
      for (int i = 0; i < 9; i++) begin
         if (i == 0) begin
            we = 1'b1; wa = 12'h340; wd = 32'hDEAD_BEEF; ra = 12'h340;
         end else begin
            we = 1'($urandom_range(0, 1));
            wa = 12'h340 + 12'($urandom_range(0, 3));
            wd = $urandom;
            ra = ($urandom_range(0, 1) == 1) ? wa : 12'h340;
         end
         exp_rd = (we && wa == ra) ? wd : regs[ra];
         ex_csr_wr_en = we; ex_csr_wr_addr = wa; ex_csr_wr_data = wd; id_csr_rd_addr = ra;
         @(negedge clk);
         checks++;
         if (id_csr_rd_data !== exp_rd || hold_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_rd[%0d]: got rd=%h hold=%b expected rd=%h hold=0", i, id_csr_rd_data, hold_o, exp_rd);
         end
         @(posedge clk); #1;
         ex_csr_wr_en = 1'b0;
         if (we) begin
            checks++;
            if (regs[wa] !== wd) begin
               errors++; $display("FAIL pass_wr[%0d]: got %h expected %h", i, regs[wa], wd);
            end
         end
      end
      id_csr_rd_addr = 12'h300;
   endtask

   task automatic test_exception(input bit directed);
      logic [31:0] ms, tv;
      ms = directed ? 32'h8 : $urandom;
      tv = directed ? 32'h200 : $urandom;
      exc_pc    = directed ? 32'h100 : $urandom;
      exc_cause = directed ? 32'd11 : 32'($urandom_range(0, 15));
      exc_tval  = directed ? 32'h0 : $urandom;
      preload(12'h300, ms);
      preload(12'h305, tv);
      exp_q.delete();
      exp_q.push_back('{c: 1, a: 12'h341, d: exc_pc});
      exp_q.push_back('{c: 2, a: 12'h342, d: exc_cause});
      exp_q.push_back('{c: 3, a: 12'h343, d: exc_tval});
      exp_q.push_back('{c: 4, a: 12'h300, d: exp_trap_ms(ms)});
      observe(8, 32'h1, 32'h0, 0, -1, 1'b1);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++; $display("FAIL exc_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL exc_wr%0d: got c%0d %h=%h expected c%0d %h=%h", i,
                     wr_q[i].c, wr_q[i].a, wr_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
         end
      end
      checks++;
      if (jmp_c.size() != 1 || jmp_c[0] != 5 || jmp_a[0] !== {tv[31:2], 2'b00}) begin
         errors++;
         $display("FAIL exc_jump: got %0d jumps first c%0d addr %h expected 1 at c5 addr %h",
                  jmp_c.size(), (jmp_c.size() > 0) ? jmp_c[0] : -1,
                  (jmp_a.size() > 0) ? jmp_a[0] : 32'h0, {tv[31:2], 2'b00});
      end
      for (int c = 0; c <= 6; c++) begin
         checks++;
         if (hold_log[c] !== (c < 6)) begin
            errors++; $display("FAIL exc_hold_c%0d: got %b expected %b", c, hold_log[c], (c < 6));
         end
      end
      checks++;
      if (idrd_log[1] !== 32'h0) begin
         errors++; $display("FAIL exc_id_rd_busy: got %h expected 0", idrd_log[1]);
      end
   endtask

   task automatic test_mret(input bit directed);
      logic [31:0] ms, ep;
      ms = directed ? 32'h80 : $urandom;
      ep = directed ? 32'h104 : $urandom;
      preload(12'h300, ms);
      preload(12'h341, ep);
      observe(4, 32'h0, 32'h1, 0, -1, 1'b0);
      checks++;
      if (wr_q.size() != 1 || wr_q[0].c != 1 || wr_q[0].a !== 12'h300 || wr_q[0].d !== exp_mret_ms(ms)) begin
         errors++;
         $display("FAIL mret_wr: got %0d writes first %h expected 1 write c1 300=%h",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0].d : 32'h0, exp_mret_ms(ms));
      end
      checks++;
      if (jmp_c.size() != 1 || jmp_c[0] != 2 || jmp_a[0] !== ep) begin
         errors++;
         $display("FAIL mret_jump: got %0d jumps first c%0d addr %h expected 1 at c2 addr %h",
                  jmp_c.size(), (jmp_c.size() > 0) ? jmp_c[0] : -1,
                  (jmp_a.size() > 0) ? jmp_a[0] : 32'h0, ep);
      end
      checks++;
      if (hold_log[2] !== 1'b1 || hold_log[3] !== 1'b0) begin
         errors++; $display("FAIL mret_hold: got c2=%b c3=%b expected 1/0", hold_log[2], hold_log[3]);
      end
   endtask

   // taken: MIE and MTIE set. reenter: irq stays high past the return to IDLE.
   task automatic test_irq(input bit taken, input bit reenter);
      logic [31:0] ms, me, tv;
      int          sel, idle_c;
      sel = $urandom_range(0, 2);
      ms  = $urandom;
      me  = $urandom;
      tv  = $urandom;
      if (taken) begin
         ms[3] = 1'b1; me[7] = 1'b1;
      end else begin
         ms[3] = (sel == 1); me[7] = (sel == 0);
      end
      irq_pc = directed_pc(taken);
      preload(12'h300, ms);
      preload(12'h304, me);
      preload(12'h305, tv);
      exp_q.delete();
      if (taken) begin
         exp_q.push_back('{c: 3, a: 12'h341, d: irq_pc});
         exp_q.push_back('{c: 4, a: 12'h342, d: 32'h8000_0007});
         exp_q.push_back('{c: 5, a: 12'h343, d: 32'h0});
         exp_q.push_back('{c: 6, a: 12'h300, d: exp_trap_ms(ms)});
      end
      idle_c = !taken ? 3 : (reenter ? 11 : 8);
      observe(idle_c + 1, 32'h0, 32'h0, reenter ? 10 : 1, -1, 1'b0);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++; $display("FAIL irq_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL irq_wr%0d: got c%0d %h=%h expected c%0d %h=%h", i,
                     wr_q[i].c, wr_q[i].a, wr_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
         end
      end
      checks++;
      if (taken) begin
         if (jmp_c.size() != 1 || jmp_c[0] != 7 || jmp_a[0] !== {tv[31:2], 2'b00}) begin
            errors++;
            $display("FAIL irq_jump: got %0d jumps first c%0d expected 1 at c7 addr %h",
                     jmp_c.size(), (jmp_c.size() > 0) ? jmp_c[0] : -1, {tv[31:2], 2'b00});
         end
      end else if (jmp_c.size() != 0) begin
         errors++; $display("FAIL irq_nojump: got %0d jumps expected 0", jmp_c.size());
      end
      checks++;
      if (hold_log[idle_c - 1] !== 1'b1 || hold_log[idle_c] !== 1'b0) begin
         errors++;
         $display("FAIL irq_hold: got c%0d=%b c%0d=%b expected 1/0",
                  idle_c - 1, hold_log[idle_c - 1], idle_c, hold_log[idle_c]);
      end
   endtask

   function automatic logic [31:0] directed_pc(input bit taken);
      return taken ? ($urandom & 32'hFFFF_FFFC) : 32'h40;
   endfunction

   // exc+mret together (trap wins), mret in W_MCAUSE (ignored), then mret
   // issued in the first idle cycle after the trap's JUMP.
   task automatic test_back_to_back();
      logic [31:0] ms, tv;
      ms = $urandom; tv = $urandom;
      exc_pc = $urandom; exc_cause = 32'd2; exc_tval = $urandom;
      preload(12'h300, ms);
      preload(12'h305, tv);
      exp_q.delete();
      exp_q.push_back('{c: 1, a: 12'h341, d: exc_pc});
      exp_q.push_back('{c: 2, a: 12'h342, d: exc_cause});
      exp_q.push_back('{c: 3, a: 12'h343, d: exc_tval});
      exp_q.push_back('{c: 4, a: 12'h300, d: exp_trap_ms(ms)});
      exp_q.push_back('{c: 7, a: 12'h300, d: exp_mret_ms(exp_trap_ms(ms))});
      observe(10, 32'h1, 32'h45, 0, -1, 1'b0);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++; $display("FAIL b2b_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL b2b_wr%0d: got c%0d %h=%h expected c%0d %h=%h", i,
                     wr_q[i].c, wr_q[i].a, wr_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
         end
      end
      checks++;
      if (jmp_c.size() != 2 || jmp_c[0] != 5 || jmp_a[0] !== {tv[31:2], 2'b00} ||
          jmp_c[1] != 8 || jmp_a[1] !== exc_pc) begin
         errors++;
         $display("FAIL b2b_jump: got %0d jumps expected c5->%h and c8->%h",
                  jmp_c.size(), {tv[31:2], 2'b00}, exc_pc);
      end
      checks++;
      if (hold_log[8] !== 1'b1 || hold_log[9] !== 1'b0) begin
         errors++; $display("FAIL b2b_hold: got c8=%b c9=%b expected 1/0", hold_log[8], hold_log[9]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ms;
      ms = $urandom;
      exc_pc = $urandom; exc_cause = 32'd3; exc_tval = $urandom;
      preload(12'h300, ms);
      observe(10, 32'h1, 32'h0, 0, 3, 1'b0);
      checks++;
      if (wr_q.size() < 2 || wr_q[0].a !== 12'h341 || wr_q[1].a !== 12'h342) begin
         errors++; $display("FAIL rmid_partial: got %0d writes expected mepc and mcause first", wr_q.size());
      end
      foreach (wr_q[i]) begin
         checks++;
         if (wr_q[i].c >= 3) begin
            errors++; $display("FAIL rmid_late_wr: got write c%0d %h expected none from c3", wr_q[i].c, wr_q[i].a);
         end
      end
      checks++;
      if (regs[12'h300] !== ms) begin
         errors++; $display("FAIL rmid_mstatus: got %h expected %h", regs[12'h300], ms);
      end
      checks++;
      if (jmp_c.size() != 0) begin
         errors++; $display("FAIL rmid_jump: got %0d jumps expected 0", jmp_c.size());
      end
      checks++;
      if (hold_log[3] !== 1'b0 || hold_log[4] !== 1'b0) begin
         errors++; $display("FAIL rmid_hold: got c3=%b c4=%b expected 0/0", hold_log[3], hold_log[4]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ex_csr_wr_en = 1'b0; ex_csr_wr_addr = '0; ex_csr_wr_data = '0;
      id_csr_rd_addr = 12'h300;
      exc_req = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
      mret_req = 1'b0; irq_timer = 1'b0; irq_pc = '0;
      rst = 1'b1;
      #1;
      test_reset();
      test_passthrough();
      test_exception(1'b1);
      for (int i = 0; i < 5; i++) test_exception(1'b0);
      test_mret(1'b1);
      for (int i = 0; i < 5; i++) test_mret(1'b0);
      for (int i = 0; i < 4; i++) test_irq(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) test_irq(1'b0, 1'b0);
      test_irq(1'b1, 1'b1);
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
